mod_mult_seq: RTL and testbench
===============================

Name: mod_mult_seq

Overview:
- Sequential modular multiplier: computes out = (x * y) mod modulant.
- Uses MSB-first double-and-add over the bits of y.
- Drives a single instance of the team's combinational modular adder (a + b mod modulant), time-shared between the double step and the add step.
- Sits between operand registers and the modular arithmetic datapath. It is the controller that sequences that adder.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits; also sets the bit-iteration count.

Ports:
- clk, input, 1, single system clock; all state changes on rising edge.
- reset, input, 1, synchronous, active-high; forces IDLE on the next rising edge.
- start, input, 1, request to begin a multiplication; sampled only when ready=1.
- ready, output, 1, block can accept start this cycle.
- x, input, DATA_WIDTH, multiplicand; caller guarantees x < modulant (or modulant=0).
- y, input, DATA_WIDTH, multiplier; any value.
- modulant, input, DATA_WIDTH, modulus; 0 means modulus 2^DATA_WIDTH.
- out, output, DATA_WIDTH, registered result.
- done, output, 1, one-cycle pulse when out is newly valid.

Behaviour:
- Reset: state=IDLE, ready=1, done=0, out=0, internal acc/bit counter=0.
- States and outputs:
  - IDLE: ready=1.
  - DBL: ready=0.
  - ADD: ready=0.
  - DONE: ready=1, done=1.
- Acceptance:
  - At a rising edge with start=1 and ready=1, latch x, y and modulant into internal registers.
  - Set acc=0 and bit index=DATA_WIDTH-1, then go to DBL.
  - Later changes on the x/y/modulant inputs have no effect on the running operation.
- DBL: adder a=acc, b=acc; acc <= adder result; go to ADD.
- ADD:
  - Adder a=acc, b = y_reg[bit] ? x_reg : 0; acc <= adder result.
  - If bit==0: out <= adder result, go to DONE.
  - Otherwise: decrement bit, go to DBL.
- Fixed latency: exactly 2*DATA_WIDTH edges after the accepting edge, done=1 and out is valid. This holds regardless of the value of y; no early termination.
- DONE: lasts one cycle.
  - With start=1, the operation is accepted immediately (back-to-back) and the state goes to DBL.
  - Otherwise the state goes to IDLE.
- out holds its value from DONE until the next DONE; it does not change while busy.
- start while ready=0 is ignored; no queuing.
- Width rules:
  - acc < modulant is invariant, so acc+acc < 2*modulant and fits in DATA_WIDTH+1 bits inside the adder.
  - The adder performs the single conditional subtract; no further reduction is needed.
- modulant=0: the adder's compare is always true and subtracts 0, so the result is the sum truncated to DATA_WIDTH bits, i.e. mod 2^DATA_WIDTH. This is a supported mode.
- x >= modulant (modulant≠0): result undefined; caller contract.
- Reset mid-operation: at the next edge return to IDLE with out=0 and done=0. The partial result is discarded.
- reset and start together: reset wins.

Decomposition:
- Shared package mod_pkg holds:
  - the typedef enum for the controller state {IDLE, DBL, ADD, DONE};
  - a localparam for the bit-counter width, $clog2(DATA_WIDTH), with minimum 1.
- Sub-module: one instance of the existing adder (parameter DATA_WIDTH passed through). The controller owns only the muxes on adder inputs a/b and the registers.

Test Plan:
- DATA_WIDTH=8, x=7, y=9, modulant=11, start pulse -> done exactly 16 edges after acceptance, out=8; ready=0 throughout busy; done high one cycle.
- x=250, y=255, modulant=251 -> out=247. Also x=0, y=200, modulant=251 -> out=0. Also y=0 -> out=0; latency is still 16 edges.
- modulant=0, x=16, y=17 -> out=16 (272 mod 256).
- start held high continuously with operands changing per operation -> each op accepted in its DONE cycle, results every 16 edges, all correct. A start pulse asserted mid-operation with different operands is ignored and the first result is unaffected.
- reset asserted on cycle 5 of an operation -> next cycle state IDLE, ready=1, out=0, done never pulses. A fresh op after reset gives the correct result.
- Randomized x<m, y, m in 1..255 against reference (x*y)%m over ≥1000 ops; out is stable between done pulses.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared definitions for the modular-arithmetic controller slice.
package mod_pkg;

    // Controller state for the sequential modular multiplier.
    typedef enum logic [1:0] {
        IDLE,
        DBL,
        ADD,
        DONE
    } state_t;

    // Width of a counter that indexes bits 0..data_width-1, never below 1.
    function automatic int bit_cnt_width(input int data_width);
        int w;
        w = $clog2(data_width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mod_mult_seq_add.sv
// Combinational modular adder: sum = (a + b) mod modulant, with a single
// conditional subtract. Both inputs must already be below modulant, so the
// raw sum is below 2*modulant. A modulant of 0 stands for 2^DATA_WIDTH:
// the compare always passes, 0 is subtracted, and the carry is dropped.
module mod_add #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH:0] raw;
    logic [DATA_WIDTH:0] mod_ext;

    // Full-width sum, then at most one subtraction of the modulus.
    always_comb begin
        raw     = {1'b0, a} + {1'b0, b};
        mod_ext = {1'b0, modulant};
        if (raw >= mod_ext) begin
            sum = DATA_WIDTH'(raw - mod_ext);
        end else begin
            sum = DATA_WIDTH'(raw);
        end
    end

endmodule

// File: rtl/mod_mult_seq.sv
// Sequential modular multiplier: out = (x * y) mod modulant, MSB-first
// double-and-add over y, time-sharing one modular adder between the double
// and add steps. Fixed latency of 2*DATA_WIDTH edges from acceptance.
module mod_mult_seq
    import mod_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  ready,
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic [DATA_WIDTH-1:0] modulant,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  done
);

    localparam int BIT_W = bit_cnt_width(DATA_WIDTH);

    state_t state_q;
    state_t state_d;

    logic [DATA_WIDTH-1:0] x_reg;
    logic [DATA_WIDTH-1:0] y_reg;
    logic [DATA_WIDTH-1:0] m_reg;
    logic [DATA_WIDTH-1:0] acc;
    logic [BIT_W-1:0]      bit_idx;

    logic                  accept;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;

    mod_add #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_add (
        .a       (acc),
        .b       (add_b),
        .modulant(m_reg),
        .sum     (add_sum)
    );

    assign last_bit = (bit_idx == '0);

    // State register; reset overrides any pending start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one DBL/ADD pair per bit of y, no early exit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DBL;
            DBL:     state_d = ADD;
            ADD:     state_d = last_bit ? DONE : DBL;
            DONE:    state_d = start ? DBL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs and adder operand selection.
    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        add_b = acc;
        case (state_q)
            IDLE: ready = 1'b1;
            DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            ADD:     add_b = y_reg[bit_idx] ? x_reg : '0;
            default: add_b = acc;
        endcase
        accept = ready & start;
    end

    // Operand capture, accumulator, bit counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg   <= '0;
            y_reg   <= '0;
            m_reg   <= '0;
            acc     <= '0;
            bit_idx <= '0;
            out     <= '0;
        end else if (accept) begin
            x_reg   <= x;
            y_reg   <= y;
            m_reg   <= modulant;
            acc     <= '0;
            bit_idx <= BIT_W'(DATA_WIDTH - 1);
        end else begin
            case (state_q)
                DBL: acc <= add_sum;
                ADD: begin
                    acc <= add_sum;
                    if (last_bit) begin
                        out <= add_sum;
                    end else begin
                        bit_idx <= bit_idx - BIT_W'(1);
                    end
                end
                default: acc <= acc;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Scoreboard bench for mod_mult_seq: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is due or asserted.
module tb_mod_mult_seq;

    localparam int W   = 8;
    localparam int LAT = 2 * W;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] modulant;
    logic [W-1:0] out;
    logic         done;

    mod_mult_seq #(
        .DATA_WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ready   (ready),
        .x       (x),
        .y       (y),
        .modulant(modulant),
        .out     (out),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int unsigned due;
        int unsigned epoch;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc       = 0;
    int unsigned epoch     = 0;
    int unsigned acc_cnt   = 0;
    bit          pending   = 1'b0;
    int unsigned pend_due  = 0;
    int unsigned pend_val  = 0;
    int unsigned model_last = 0;
    int          checks    = 0;
    int          failures  = 0;
    bit          stim_done = 1'b0;

    function automatic int unsigned ref_mul(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        int unsigned p;
        p = a * b;
        if (m == 0) return p % 256;
        return p % m;
    endfunction

    // Reference timing/acceptance model, evaluated on the same edge the DUT samples.
    always @(posedge clk) begin
        bit mready;
        mready = !pending || (cyc == pend_due);
        if (reset) begin
            pending    = 1'b0;
            model_last = 0;
            epoch      = epoch + 1;
        end else begin
            if (pending && (cyc + 1 == pend_due)) model_last = pend_val;
            if (pending && (cyc == pend_due)) pending = 1'b0;
            if (start && mready) begin
                exp_t e;
                pending  = 1'b1;
                pend_due = cyc + 1 + LAT;
                pend_val = ref_mul(x, y, modulant);
                e.val    = pend_val;
                e.due    = pend_due;
                e.epoch  = epoch;
                sb.push_back(e);
                acc_cnt  = acc_cnt + 1;
            end
        end
        cyc = cyc + 1;
    end

    // Monitor: ready, done timing, result value and result stability.
    always @(negedge clk) begin
        bit          exp_ready;
        bit          exp_done;
        int unsigned exp_val;
        if (cyc > 0) begin
            while (sb.size() > 0 && sb[0].epoch != epoch) void'(sb.pop_front());
            exp_ready = !pending || (cyc == pend_due);
            exp_done  = (sb.size() > 0) && (sb[0].due == cyc);
            checks++;
            if (ready !== exp_ready) begin
                failures++;
                $display("FAIL ready cyc=%0d got=%b want=%b", cyc, ready, exp_ready);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, exp_done);
            end
            if (exp_done) begin
                exp_val = sb[0].val;
                void'(sb.pop_front());
            end else begin
                exp_val = model_last;
            end
            checks++;
            if (out !== W'(exp_val)) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%0d want=%0d",
                         exp_done ? "result" : "hold", cyc, out, exp_val);
            end
        end
    end

    // Drive an operation and wait (bounded) until the model records acceptance.
    task automatic issue(input int unsigned a, input int unsigned b,
                         input int unsigned m, input bit keep);
        int unsigned c0;
        bit          ok;
        @(negedge clk);
        c0       = acc_cnt;
        x        = W'(a);
        y        = W'(b);
        modulant = W'(m);
        start    = 1'b1;
        ok       = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout got=none want=accepted");
        end
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pending) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int unsigned m;
        reset    = 1'b1;
        start    = 1'b0;
        x        = '0;
        y        = '0;
        modulant = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic op with a mid-operation start pulse that must be ignored.
        issue(7, 9, 11, 1'b0);
        repeat (3) @(negedge clk);
        x = 8'd100; y = 8'd3; modulant = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        x = 8'd55; y = 8'd66; modulant = 8'd77;
        wait_idle();

        // Directed corner values, including y=0 and modulus 2^8.
        issue(250, 255, 251, 1'b0); wait_idle();
        issue(0, 200, 251, 1'b0);   wait_idle();
        issue(5, 0, 13, 1'b0);      wait_idle();
        issue(16, 17, 0, 1'b0);     wait_idle();
        issue(255, 255, 0, 1'b0);   wait_idle();

        // Back-to-back with start held high and fresh operands each op.
        for (int i = 0; i < 6; i++) begin
            m = $urandom_range(1, 255);
            issue($urandom_range(0, m - 1), $urandom_range(0, 255), m, 1'b1);
        end
        start = 1'b0;
        wait_idle();

        // Reset in the middle of an operation, then a fresh op.
        issue(200, 201, 251, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        issue(7, 9, 11, 1'b0);
        wait_idle();

        // Randomized operations with random gaps and occasional streaming.
        for (int i = 0; i < 1000; i++) begin
            bit keep;
            if ($urandom_range(0, 15) == 0) m = 0;
            else m = $urandom_range(1, 255);
            keep = ($urandom_range(0, 3) == 0);
            issue((m == 0) ? $urandom_range(0, 255) : $urandom_range(0, m - 1),
                  $urandom_range(0, 255), m, keep);
            if (!keep) repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        stim_done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        if (!stim_done) begin
            $display("FAIL watchdog got=running want=finished");
            $fatal(1, "watchdog expired");
        end
    end

endmodule
